mem_request_arbiter: RTL
========================

MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: maximum outstanding reads and maximum outstanding writes; power of two, 2 to 16.
REQ-002 Ports (name, direction, width, meaning):
- clk in 1: rising-edge clock.
- reset in 1: asynchronous, active-high reset.
- cN_req in 1 (N=0,1): client N request valid.
- cN_we in 1: client N op; 1 = write, 0 = read.
- cN_address in 16: client N address.
- cN_wdata in 16: client N write data.
- cN_gnt out 1: client N request accepted this cycle.
- cN_ret_ack out 1: client N response valid.
- cN_ret_address out 16: client N response address.
- cN_ret_data out 16: client N read data; 0 on write responses.
- mc_wr_en, mc_rd_en out 1: memory controller write and read enables.
- mc_wr_address, mc_rd_address out 16: memory controller addresses.
- mc_wr_data out 16: memory controller write data.
- mc_wr_ret_ack, mc_rd_ret_ack in 1: memory controller response valids.
- mc_wr_ret_address, mc_rd_ret_address in 16: memory controller response addresses.
- mc_rd_ret_data in 16: memory controller read data.
- drain_req in 1: stop issuing and wait for all responses.
- drain_done out 1: drained, no requests outstanding.
- err out 1: sticky protocol error.

Function
REQ-003 The block SHALL grant at most one client per cycle; cN_gnt is combinational from current inputs and state.
REQ-004 With both clients requesting and eligible, the block SHALL grant the client not granted most recently (1-bit round-robin pointer, updated on every grant); the pointer favours client 0 after reset.
REQ-005 A request SHALL be eligible only in state RUN, only if its op's tag FIFO holds fewer than DEPTH entries, and only when no pop occurs in the same cycle.
REQ-006 On a grant the block SHALL register the request onto the matching mc port the next cycle: mc_*_en=1 for exactly one cycle, with the address and data captured at grant; the other port's en=0.
REQ-007 Each grant SHALL push the granted client id (1 bit) into the read tag FIFO or the write tag FIFO, per cN_we.
REQ-008 Responses from the memory controller are returned in issue order per port.
REQ-009 On mc_rd_ret_ack the block SHALL pop the read tag FIFO and, in the same cycle, drive cN_ret_ack=1, cN_ret_address and cN_ret_data to the client at the FIFO head.
REQ-010 Write responses SHALL be handled the same way using the write tag FIFO, with cN_ret_data=0.
REQ-011 When a read and a write response target the same client in one cycle, the read SHALL be delivered and the write held in a 1-entry skid register, delivered the next cycle.
- While the skid register is full, the write tag FIFO SHALL NOT pop and mc_wr_ret_ack sets err.
REQ-012 A response arriving with its tag FIFO empty SHALL be dropped and SHALL set err until reset.
REQ-013 FSM states and transitions:
- RUN -> DRAIN when drain_req=1.
- DRAIN -> DRAINED when both FIFOs and the skid register are empty and no mc_*_en is pending.
- DRAINED -> RUN when drain_req=0.
- DRAIN and DRAINED issue no grants.
REQ-014 drain_done SHALL be 1 only in DRAINED.
REQ-015 Tag FIFO pointers SHALL wrap modulo DEPTH, with a separate occupancy count 0..DEPTH.

Reset
REQ-016 reset SHALL immediately force: all outputs 0, FIFOs empty, skid register empty, pointer to client 0, state RUN, err 0.
REQ-017 Requests in flight when reset is asserted SHALL be forgotten; their later responses SHALL set err.

Configuration
REQ-018 With ARB_STATS_EN defined, the block SHALL add outputs c0_grant_count and c1_grant_count (16 bits each), incremented on each grant, saturating at 0xFFFF, and cleared by reset.
REQ-019 Without ARB_STATS_EN, these ports and counters SHALL NOT exist, and all other behaviour is identical.

Verification
REQ-020 Both clients reading continuously, memory controller returning reads 3 cycles later -> grants alternate c0,c1,c0,...; each client receives its own address back.
REQ-021 DEPTH=4, c0 issues 5 reads, no returns -> 4 grants, 5th stalled; one mc_rd_ret_ack -> 5th granted the cycle after the pop.
REQ-022 Same-cycle read and write responses to c1 -> read delivered in cycle T, write delivered in cycle T+1.
REQ-023 drain_req with 3 outstanding reads -> no grants; drain_done=1 after the 3rd return; drain_req=0 -> RUN resumes.
REQ-024 mc_wr_ret_ack with an empty write FIFO -> err=1 and stays 1; reset -> err=0.
REQ-025 ARB_STATS_EN defined, 0x10000 grants to c0 -> c0_grant_count holds at 0xFFFF.

Source files
------------

// File: rtl/mem_request_arbiter.sv
// Two-client round-robin arbiter in front of a split read/write memory controller port pair.
// Define ARB_STATS_EN to add saturating per-client grant counters.
module mem_request_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c0_req,
    input  logic        c0_we,
    input  logic [15:0] c0_address,
    input  logic [15:0] c0_wdata,
    output logic        c0_gnt,
    output logic        c0_ret_ack,
    output logic [15:0] c0_ret_address,
    output logic [15:0] c0_ret_data,
    input  logic        c1_req,
    input  logic        c1_we,
    input  logic [15:0] c1_address,
    input  logic [15:0] c1_wdata,
    output logic        c1_gnt,
    output logic        c1_ret_ack,
    output logic [15:0] c1_ret_address,
    output logic [15:0] c1_ret_data,
    output logic        mc_wr_en,
    output logic        mc_rd_en,
    output logic [15:0] mc_wr_address,
    output logic [15:0] mc_rd_address,
    output logic [15:0] mc_wr_data,
    input  logic        mc_wr_ret_ack,
    input  logic        mc_rd_ret_ack,
    input  logic [15:0] mc_wr_ret_address,
    input  logic [15:0] mc_rd_ret_address,
    input  logic [15:0] mc_rd_ret_data,
    input  logic        drain_req,
    output logic        drain_done,
    output logic        err
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] c0_grant_count,
    output logic [15:0] c1_grant_count
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DRAINED} state_t;
    state_t state, state_nxt;

    logic [DEPTH-1:0] rd_tag, wr_tag;
    logic [PW-1:0]    rd_wp, rd_rp, wr_wp, wr_rp;
    logic [CW-1:0]    rd_cnt, wr_cnt;
    logic             skid_vld, skid_client;
    logic [15:0]      skid_addr;
    logic             rr_ptr;

    logic        rd_head, wr_head;
    logic        rd_pop, wr_pop, wr_to_skid, skid_fire;
    logic        rd_room, wr_room, issue_ok, elig0, elig1, any_gnt;
    logic        g_id, g_we;
    logic [15:0] g_addr, g_data;
    logic        rd_push, wr_push, err_set;

    assign rd_head = rd_tag[rd_rp];
    assign wr_head = wr_tag[wr_rp];
    assign rd_room = rd_cnt < CW'(DEPTH);
    assign wr_room = wr_cnt < CW'(DEPTH);

    // A write whose client also gets a read this cycle parks in the skid slot;
    // the slot then drains on the first cycle that client is not receiving a read.
    always_comb begin
        rd_pop     = mc_rd_ret_ack && (rd_cnt != '0);
        wr_pop     = mc_wr_ret_ack && !skid_vld && (wr_cnt != '0);
        wr_to_skid = wr_pop && rd_pop && (rd_head == wr_head);
        skid_fire  = skid_vld && !(rd_pop && (rd_head == skid_client));
        err_set    = (mc_rd_ret_ack && (rd_cnt == '0)) ||
                     (mc_wr_ret_ack && (skid_vld || (wr_cnt == '0)));
    end

    always_comb begin
        issue_ok = (state == S_RUN) && !reset && !rd_pop && !wr_pop;
        elig0    = issue_ok && c0_req && (c0_we ? wr_room : rd_room);
        elig1    = issue_ok && c1_req && (c1_we ? wr_room : rd_room);
        c0_gnt   = elig0 && (!elig1 || !rr_ptr);
        c1_gnt   = elig1 && (!elig0 || rr_ptr);
        any_gnt  = c0_gnt || c1_gnt;
        g_id     = c1_gnt;
        g_we     = c1_gnt ? c1_we      : c0_we;
        g_addr   = c1_gnt ? c1_address : c0_address;
        g_data   = c1_gnt ? c1_wdata   : c0_wdata;
        rd_push  = any_gnt && !g_we;
        wr_push  = any_gnt && g_we;
    end

    logic [1:0]  ret_ack;
    logic [15:0] ret_addr [2];
    logic [15:0] ret_data [2];

    always_comb begin
        ret_ack     = '0;
        ret_addr[0] = '0;
        ret_addr[1] = '0;
        ret_data[0] = '0;
        ret_data[1] = '0;
        if (rd_pop) begin
            ret_ack[rd_head]  = 1'b1;
            ret_addr[rd_head] = mc_rd_ret_address;
            ret_data[rd_head] = mc_rd_ret_data;
        end
        if (wr_pop && !wr_to_skid) begin
            ret_ack[wr_head]  = 1'b1;
            ret_addr[wr_head] = mc_wr_ret_address;
        end
        if (skid_fire) begin
            ret_ack[skid_client]  = 1'b1;
            ret_addr[skid_client] = skid_addr;
        end
    end

    assign c0_ret_ack     = ret_ack[0];
    assign c1_ret_ack     = ret_ack[1];
    assign c0_ret_address = ret_addr[0];
    assign c1_ret_address = ret_addr[1];
    assign c0_ret_data    = ret_data[0];
    assign c1_ret_data    = ret_data[1];

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:     if (drain_req) state_nxt = S_DRAIN;
            S_DRAIN:   if ((rd_cnt == '0) && (wr_cnt == '0) && !skid_vld && !mc_rd_en && !mc_wr_en)
                           state_nxt = S_DRAINED;
            S_DRAINED: if (!drain_req) state_nxt = S_RUN;
            default:   state_nxt = S_RUN;
        endcase
    end

    assign drain_done = (state == S_DRAINED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_RUN;
            rr_ptr        <= 1'b0;
            mc_rd_en      <= 1'b0;
            mc_wr_en      <= 1'b0;
            mc_rd_address <= '0;
            mc_wr_address <= '0;
            mc_wr_data    <= '0;
            rd_tag        <= '0;
            wr_tag        <= '0;
            rd_wp         <= '0;
            rd_rp         <= '0;
            wr_wp         <= '0;
            wr_rp         <= '0;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
            skid_vld      <= 1'b0;
            skid_client   <= 1'b0;
            skid_addr     <= '0;
            err           <= 1'b0;
        end else begin
            state    <= state_nxt;
            mc_rd_en <= rd_push;
            mc_wr_en <= wr_push;
            if (rd_push) mc_rd_address <= g_addr;
            if (wr_push) begin
                mc_wr_address <= g_addr;
                mc_wr_data    <= g_data;
            end
            if (any_gnt) rr_ptr <= ~g_id;

            if (rd_push) begin
                rd_tag[rd_wp] <= g_id;
                rd_wp         <= rd_wp + 1'b1;
            end
            if (rd_pop) rd_rp <= rd_rp + 1'b1;
            case ({rd_push, rd_pop})
                2'b10:   rd_cnt <= rd_cnt + 1'b1;
                2'b01:   rd_cnt <= rd_cnt - 1'b1;
                default: ;
            endcase

            if (wr_push) begin
                wr_tag[wr_wp] <= g_id;
                wr_wp         <= wr_wp + 1'b1;
            end
            if (wr_pop) wr_rp <= wr_rp + 1'b1;
            case ({wr_push, wr_pop})
                2'b10:   wr_cnt <= wr_cnt + 1'b1;
                2'b01:   wr_cnt <= wr_cnt - 1'b1;
                default: ;
            endcase

            if (wr_to_skid) begin
                skid_vld    <= 1'b1;
                skid_client <= wr_head;
                skid_addr   <= mc_wr_ret_address;
            end else if (skid_fire) begin
                skid_vld <= 1'b0;
            end

            if (err_set) err <= 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c0_grant_count <= '0;
            c1_grant_count <= '0;
        end else begin
            if (c0_gnt && (c0_grant_count != 16'hFFFF)) c0_grant_count <= c0_grant_count + 16'd1;
            if (c1_gnt && (c1_grant_count != 16'hFFFF)) c1_grant_count <= c1_grant_count + 16'd1;
        end
    end
`endif

endmodule
